gf_vme_slave_ctrl: RTL

//  VME A24/D32 slave front end for the GigaFitter register bank. Synchronises the

---
 rtl/gf_vme_slave_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/gf_vme_slave_ctrl.sv
// gf_vme_slave_ctrl: VME A24/D32 slave front end driving the GigaFitter register bank strobes.
module gf_vme_slave_ctrl #(
  parameter int WR_WAIT = 3,
  parameter int RD_WAIT = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        vme_as_n,
  input  logic        vme_ds0_n,
  input  logic        vme_ds1_n,
  input  logic        vme_write_n,
  input  logic        vme_lword_n,
  input  logic [5:0]  vme_am,
  input  logic [23:1] vme_addr,
  input  logic [7:0]  base_addr,
  output logic [15:0] address,
  output logic        writeRegister,
  output logic        readRegister,
  output logic        vme_dtack_n,
  output logic        vme_berr_n,
  output logic        vme_data_oe_n,
  output logic        vme_data_dir,
  output logic        timeout_pulse
);
  typedef enum logic [3:0] {IDLE, DECODE, IGNORE, WAITDS, WRITE, READ, ACK, BERR, RELEASE} state_t;
  state_t state;
  logic [4:0] syncA, syncB;
  logic [5:0] amL;
  logic [23:2] addrL;
  logic [7:0] waitCnt;
  logic [9:0] wdCnt;
  logic asS, ds0S, ds1S, writeS, lwordS, dsLow, dsHigh, hit;
  assign {asS, ds0S, ds1S, writeS, lwordS} = syncB;
  assign dsLow = ~ds0S & ~ds1S;
  assign dsHigh = ds0S & ds1S;
  assign hit = (amL == 6'h39 || amL == 6'h3D) && addrL[23:16] == base_addr;
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state <= IDLE;
      syncA <= '1;
      syncB <= '1;
      amL <= '0;
      addrL <= '0;
      waitCnt <= '0;
      wdCnt <= '0;
      address <= '0;
      writeRegister <= 1'b0;
      readRegister <= 1'b0;
      vme_dtack_n <= 1'b1;
      vme_berr_n <= 1'b1;
      vme_data_oe_n <= 1'b1;
      vme_data_dir <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      syncA <= {vme_as_n, vme_ds0_n, vme_ds1_n, vme_write_n, vme_lword_n};
      syncB <= syncA;
      timeout_pulse <= 1'b0;
      wdCnt <= state == IDLE ? '0 : wdCnt + 10'd1;
      // Watchdog abort overrides whatever state the cycle is stuck in
      if (state != IDLE && wdCnt == 10'(TIMEOUT - 1)) begin
        state <= IDLE;
        address <= '0;
        writeRegister <= 1'b0;
        readRegister <= 1'b0;
        vme_dtack_n <= 1'b1;
        vme_berr_n <= 1'b1;
        vme_data_oe_n <= 1'b1;
        vme_data_dir <= 1'b0;
        timeout_pulse <= 1'b1;
      end else begin
        case (state)
          IDLE: if (!asS) begin
            amL <= vme_am;
            addrL <= vme_addr[23:2];
            state <= DECODE;
          end
          DECODE: begin
            if (hit) address <= {addrL[15:2], 2'b00};
            state <= hit ? WAITDS : IGNORE;
          end
          IGNORE: if (asS) state <= IDLE;
          WAITDS: if (dsLow) begin
            waitCnt <= '0;
            if (lwordS) begin
              vme_berr_n <= 1'b0;
              state <= BERR;
            end else begin
              writeRegister <= ~writeS;
              readRegister <= writeS;
              vme_data_oe_n <= 1'b0;
              vme_data_dir <= writeS;
              state <= writeS ? READ : WRITE;
            end
          end
          WRITE, READ: begin
            if (waitCnt == (state == WRITE ? 8'(WR_WAIT - 1) : 8'(RD_WAIT - 1))) begin
              vme_dtack_n <= 1'b0;
              state <= ACK;
            end else waitCnt <= waitCnt + 8'd1;
          end
          ACK, BERR: if (dsHigh) begin
            vme_dtack_n <= 1'b1;
            vme_berr_n <= 1'b1;
            writeRegister <= 1'b0;
            readRegister <= 1'b0;
            vme_data_oe_n <= 1'b1;
            vme_data_dir <= 1'b0;
            state <= RELEASE;
          end
          RELEASE: if (asS) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
